// File: rtl/alu_writeback.sv
`default_nettype none
// ============================================================================
// Module   : alu_writeback
// Purpose  : Result writeback unit for the ALU datapath. Takes one 16-bit
//            result per valid/ready handshake and stores it into byte-wide
//            little-endian memory, either as a single byte or as a word
//            (low byte at addr, high byte at addr+1, address wraps).
// Ports    : Clock, Reset_n     - rising-edge clock, async active-low reset
//            in_valid/in_ready  - request handshake (ready only when idle)
//            in_data/in_addr    - result word and destination byte address
//            in_byte            - 1 = byte op, 0 = word op
//            in_psw/psw_q       - PSW in / committed PSW (ALU_WB_PSW_EN only)
//            mem_we/mem_addr/mem_wdata/mem_ready - byte write port
//            done               - one-cycle pulse after final byte accepted
// Options  : `define ALU_WB_PSW_EN to add PSW latching and commit.
// Revision : 1.0 - initial release
// ============================================================================
module alu_writeback #(
  parameter int ADDR_W = 16
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_data,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic              in_byte,
`ifdef ALU_WB_PSW_EN
  input  logic [15:0]       in_psw,
`endif
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ready,
  output logic              done
`ifdef ALU_WB_PSW_EN
  ,
  output logic [15:0]       psw_q
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [15:0]         data_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                byte_q;
  logic                done_q;
  logic                accept;
  logic                final_ack;

  assign accept = (state_q == IDLE) && in_valid;

  // Final byte of the request is being taken by memory this cycle.
  assign final_ack = mem_ready &&
                     (((state_q == WR_LO) && byte_q) || (state_q == WR_HI));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = WR_LO;
      WR_LO:   if (mem_ready) state_d = byte_q ? IDLE : WR_HI;
      WR_HI:   if (mem_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      addr_q  <= '0;
      byte_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= final_ack;
      if (accept) begin
        data_q <= in_data;
        addr_q <= in_addr;
        byte_q <= in_byte;
      end
    end
  end

`ifdef ALU_WB_PSW_EN
  logic [15:0] psw_lat_q;

  // PSW is latched with the request and committed on the same edge that
  // raises done, so flags and memory become visible together.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      psw_lat_q <= '0;
      psw_q     <= '0;
    end else begin
      if (accept)    psw_lat_q <= in_psw;
      if (final_ack) psw_q     <= psw_lat_q;
    end
  end
`endif

  // Outputs decode straight from the state register so mem_we drops as soon
  // as the asynchronous reset clears it, and stay frozen while stalled.
  assign in_ready  = (state_q == IDLE);
  assign mem_we    = (state_q != IDLE);
  assign mem_addr  = (state_q == WR_HI) ? (addr_q + ADDR_W'(1)) : addr_q;
  assign mem_wdata = (state_q == WR_HI) ? data_q[15:8] : data_q[7:0];
  assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_writeback
// Purpose  : Self-checking bench for alu_writeback. A reference model keeps
//            the queue of byte writes each accepted request must produce and
//            a sparse memory image; directed cases are followed by random
//            traffic with random memory back-pressure.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_writeback;

  logic        Clock;
  logic        Reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [15:0] in_addr;
  logic        in_byte;
  logic [15:0] in_psw;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ready;
  logic        done;
`ifdef ALU_WB_PSW_EN
  logic [15:0] psw_q;
`endif

  alu_writeback #(.ADDR_W(16)) dut (
    .Clock     (Clock),
    .Reset_n   (Reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_addr   (in_addr),
    .in_byte   (in_byte),
`ifdef ALU_WB_PSW_EN
    .in_psw    (in_psw),
`endif
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .done      (done)
`ifdef ALU_WB_PSW_EN
    ,
    .psw_q     (psw_q)
`endif
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // One pending byte write expected from the DUT.
  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    bit          last;
    logic [15:0] psw;
  } wr_t;

  wr_t         exp_q[$];
  logic [7:0]  tbmem [logic [15:0]];
  logic [15:0] exp_psw;
  int          n_chk;
  int          n_pass;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  // One clock of traffic. Called just after a rising edge; checks the
  // visible outputs against the model, then advances one edge and updates
  // the model with whatever was written / accepted on that edge.
  task automatic step(input bit v, input logic [15:0] d, input logic [15:0] a,
                      input bit b, input logic [15:0] p, input bit r);
    bit          wr, acc, was_last;
    logic [15:0] wa, a1;
    logic [7:0]  wd;
    wr_t         f;
    in_valid = v; in_data = d; in_addr = a; in_byte = b; in_psw = p; mem_ready = r;
    #1;
    check("in_ready", in_ready, exp_q.size() == 0);
    check("mem_we", mem_we, exp_q.size() != 0);
    if (exp_q.size() != 0 && mem_we) begin
      check("mem_addr", mem_addr, exp_q[0].a);
      check("mem_wdata", mem_wdata, exp_q[0].d);
    end
    wr  = mem_we && r;
    acc = v && in_ready;
    wa  = mem_addr;
    wd  = mem_wdata;
    @(posedge Clock);
    #1;
    was_last = 1'b0;
    if (wr) begin
      tbmem[wa] = wd;
      if (exp_q.size() == 0) begin
        check("spurious_write", 1, 0);
      end else begin
        f = exp_q.pop_front();
        was_last = f.last;
        if (f.last) exp_psw = f.psw;
      end
    end
    if (acc) begin
      if (b) begin
        exp_q.push_back('{a: a, d: d[7:0], last: 1'b1, psw: p});
      end else begin
        a1 = a + 16'd1;
        exp_q.push_back('{a: a,  d: d[7:0],  last: 1'b0, psw: p});
        exp_q.push_back('{a: a1, d: d[15:8], last: 1'b1, psw: p});
      end
    end
    check("done", done, was_last);
`ifdef ALU_WB_PSW_EN
    check("psw_q", psw_q, exp_psw);
`endif
  endtask

  initial begin
    n_chk = 0; n_pass = 0; exp_psw = '0;
    Reset_n = 1'b0; in_valid = 0; in_data = '0; in_addr = '0; in_byte = 0;
    in_psw = '0; mem_ready = 0;
    #2;
    check("rst_in_ready", in_ready, 1);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_done", done, 0);
`ifdef ALU_WB_PSW_EN
    check("rst_psw_q", psw_q, 0);
`endif
    @(posedge Clock); #1;
    Reset_n = 1'b1;

    // Word write BEEF @ 0x0010, then back-to-back word accepted on done.
    step(1, 16'hBEEF, 16'h0010, 0, 16'h0013, 1);
    step(0, 16'h0000, 16'h0000, 0, 16'h0000, 1);
    step(0, 16'h0000, 16'h0000, 0, 16'h0000, 1);
    check("word_lo", tbmem[16'h0010], 8'hEF);
    check("word_hi", tbmem[16'h0011], 8'hBE);
    step(1, 16'h7788, 16'h0030, 0, 16'h0004, 1);
    step(0, 16'h0000, 16'h0000, 0, 16'h0000, 1);
    step(0, 16'h0000, 16'h0000, 0, 16'h0000, 1);
    step(0, 16'h0000, 16'h0000, 0, 16'h0000, 1);

    // Byte write 12AB @ 0x0021: only 0x21 touched.
    step(1, 16'h12AB, 16'h0021, 1, 16'h0000, 1);
    step(0, 16'h0000, 16'h0000, 0, 16'h0000, 1);
    step(0, 16'h0000, 16'h0000, 0, 16'h0000, 1);
    check("byte_wr", tbmem[16'h0021], 8'hAB);
    check("byte_no_hi", tbmem.exists(16'h0022), 0);

    // Stall in WR_LO for three cycles; inputs wiggle with no effect.
    step(1, 16'h1234, 16'h0040, 0, 16'h0000, 0);
    for (int i = 0; i < 3; i++)
      step(1, 16'hFFFF, 16'h9999, 1, 16'h0000, 0);
    step(0, 16'h0000, 16'h0000, 0, 16'h0000, 1);
    step(0, 16'h0000, 16'h0000, 0, 16'h0000, 1);
    step(0, 16'h0000, 16'h0000, 0, 16'h0000, 1);
    check("stall_lo", tbmem[16'h0040], 8'h34);
    check("stall_hi", tbmem[16'h0041], 8'h12);

    // Address wrap.
    step(1, 16'hA55A, 16'hFFFF, 0, 16'h0000, 1);
    step(0, 16'h0000, 16'h0000, 0, 16'h0000, 1);
    step(0, 16'h0000, 16'h0000, 0, 16'h0000, 1);
    step(0, 16'h0000, 16'h0000, 0, 16'h0000, 1);
    check("wrap_lo", tbmem[16'hFFFF], 8'h5A);
    check("wrap_hi", tbmem[16'h0000], 8'hA5);

    // Reset during WR_HI.
    step(1, 16'hCAFE, 16'h0100, 0, 16'h0055, 1);
    step(0, 16'h0000, 16'h0000, 0, 16'h0000, 1);
    mem_ready = 1'b0;
    Reset_n = 1'b0;
    #1;
    check("rstmid_mem_we", mem_we, 0);
    check("rstmid_in_ready", in_ready, 1);
    check("rstmid_done", done, 0);
`ifdef ALU_WB_PSW_EN
    check("rstmid_psw_q", psw_q, 0);
`endif
    exp_q.delete();
    exp_psw = '0;
    @(posedge Clock); #2;
    Reset_n = 1'b1;
    @(posedge Clock); #1;
    check("rstmid_lo_kept", tbmem[16'h0100], 8'hFE);
    check("rstmid_hi_unwritten", tbmem.exists(16'h0101), 0);
    check("rstmid_no_done", done, 0);
    step(0, 16'h0000, 16'h0000, 0, 16'h0000, 1);

    // Random traffic with random back-pressure.
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
           $urandom_range(0, 1) == 1, 16'($urandom), ($urandom_range(0, 3) != 0));

    // Drain with a bounded budget.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++)
      step(0, 16'h0000, 16'h0000, 0, 16'h0000, 1);
    check("drain_empty", exp_q.size(), 0);
    step(0, 16'h0000, 16'h0000, 0, 16'h0000, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
